// File: rtl/lfsr_prng_multi.sv
// Parametrised Fibonacci LFSR stimulus source: multi-shift advance, runtime reseed
// with zero-seed protection, discard warmup, valid/ready output and period-wrap pulse.
module lfsr_prng_multi #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] INIT_SEED = 8'hAB,
    parameter int               STEPS     = 1,
    parameter int               WARMUP    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] random,
    output logic             wrap,
    output logic             seed_fixed
);

    typedef enum logic {WARM, RUN} fsm_t;

    localparam fsm_t       START     = (WARMUP > 0) ? WARM : RUN;
    localparam logic [7:0] WARM_LAST = 8'((WARMUP > 0) ? WARMUP - 1 : 0);

    fsm_t             fsm, fsm_d;
    logic [7:0]       warm_cnt, warm_d;
    logic [WIDTH-1:0] state, state_d, seed_q, seed_d, next_state;
    logic             adv, wrap_q, wrap_d, fixed_q, fixed_d;

    // STEPS single shifts unrolled into one combinational advance
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        t = s;
        for (int i = 0; i < STEPS; i++) begin
            t = {t[WIDTH-2:0], ^(t & TAPS)};
        end
        return t;
    endfunction

    assign next_state = advance(state);

    always_comb begin
        fsm_d   = fsm;
        warm_d  = warm_cnt;
        state_d = state;
        seed_d  = seed_q;
        fixed_d = 1'b0;
        adv     = 1'b0;
        if (en) begin
            if (seed_load) begin
                // A load wins over a same-edge transfer: the consumer keeps the old word,
                // the advance is dropped.
                state_d = (seed_in == '0) ? INIT_SEED : seed_in;
                seed_d  = state_d;
                fixed_d = (seed_in == '0);
                warm_d  = 8'd0;
                fsm_d   = START;
            end else begin
                case (fsm)
                    WARM: begin
                        adv    = 1'b1;
                        warm_d = warm_cnt + 8'd1;
                        if (warm_cnt == WARM_LAST) fsm_d = RUN;
                    end
                    RUN:     adv = out_ready;
                    default: adv = 1'b0;
                endcase
                if (adv) state_d = next_state;
            end
        end
        wrap_d = adv && (next_state == seed_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= START;
            warm_cnt <= 8'd0;
            state    <= INIT_SEED;
            seed_q   <= INIT_SEED;
            wrap_q   <= 1'b0;
            fixed_q  <= 1'b0;
        end else begin
            fsm      <= fsm_d;
            warm_cnt <= warm_d;
            state    <= state_d;
            seed_q   <= seed_d;
            wrap_q   <= wrap_d;
            fixed_q  <= fixed_d;
        end
    end

    assign out_valid  = (fsm == RUN) && en && !rst;
    assign random     = state;
    assign wrap       = wrap_q && en;
    assign seed_fixed = fixed_q && en;

endmodule

// File: tb/tb_lfsr_prng_multi.sv
// Bench for lfsr_prng_multi: default, two-shift and warmup instances checked
// against a parity-based LFSR reference model.
module tb_lfsr_prng_multi;

    logic       clk = 1'b0;
    logic       rst, seed_load, out_ready;
    logic [7:0] seed_in;
    logic       en0, en1, en2;
    logic       v0, v1, v2, w0, w1, w2, f0, f1, f2;
    logic [7:0] r0, r1, r2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfsr_prng_multi u0 (.clk(clk), .rst(rst), .en(en0), .seed_load(seed_load), .seed_in(seed_in),
        .out_ready(out_ready), .out_valid(v0), .random(r0), .wrap(w0), .seed_fixed(f0));
    lfsr_prng_multi #(.STEPS(2)) u1 (.clk(clk), .rst(rst), .en(en1), .seed_load(seed_load),
        .seed_in(seed_in), .out_ready(out_ready), .out_valid(v1), .random(r1), .wrap(w1),
        .seed_fixed(f1));
    lfsr_prng_multi #(.WARMUP(4)) u2 (.clk(clk), .rst(rst), .en(en2), .seed_load(seed_load),
        .seed_in(seed_in), .out_ready(out_ready), .out_valid(v2), .random(r2), .wrap(w2),
        .seed_fixed(f2));

    // Reference: new bit = parity of tapped bits (x^8+x^6+x^5+x^4+1), shifted in at the bottom
    function automatic logic [7:0] model_adv(input logic [7:0] x, input int n);
        int v;
        v = x;
        for (int i = 0; i < n; i++) begin
            v = ((v * 2) % 256) + ($countones(v & 8'hB8) % 2);
        end
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_r;
    logic [7:0] seq_def [4];
    bit         seen [256];
    int         distinct;
    logic       exp_wrap;

    initial begin
        seq_def = '{8'h57, 8'hAF, 8'h5F, 8'hBE};
        rst = 1'b1; seed_load = 1'b0; seed_in = 8'h00; out_ready = 1'b0;
        en0 = 1'b1; en1 = 1'b0; en2 = 1'b0;
        tick(); tick();
        chk("rst_valid", v0, 0);
        chk("rst_random", r0, 8'hAB);
        chk("rst_wrap", w0, 0);
        chk("rst_fixed", f0, 0);

        rst = 1'b0; out_ready = 1'b1; #1;
        chk("first_valid", v0, 1);
        chk("first_random", r0, 8'hAB);
        exp_r = 8'hAB;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_r = model_adv(exp_r, 1);
            chk("seq_model", r0, exp_r);
            chk("seq_table", r0, seq_def[i]);
        end

        // Full period: wrap exactly after the 255th transfer, all values distinct
        rst = 1'b1; tick(); rst = 1'b0;
        exp_r = 8'hAB;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            exp_r = model_adv(exp_r, 1);
            chk("period_random", r0, exp_r);
            chk("period_wrap", w0, (i == 255) ? 1 : 0);
            seen[r0] = 1'b1;
        end
        chk("period_end", r0, 8'hAB);
        distinct = 0;
        for (int i = 1; i < 256; i++) if (seen[i]) distinct++;
        chk("period_distinct", distinct, 255);
        chk("period_zero", seen[0], 0);

        // Randomised enable/ready traffic
        for (int i = 0; i < 120; i++) begin
            en0 = ($urandom_range(3) != 0);
            out_ready = $urandom_range(1);
            #1;
            chk("rnd_valid", v0, en0);
            exp_wrap = en0 && out_ready && (model_adv(exp_r, 1) == 8'hAB);
            tick();
            if (en0 && out_ready) exp_r = model_adv(exp_r, 1);
            chk("rnd_random", r0, exp_r);
            chk("rnd_wrap", w0, exp_wrap);
        end

        en0 = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_valid", v0, 0);
            tick();
            chk("hold_random", r0, exp_r);
        end
        en0 = 1'b1;

        // Zero seed with a same-edge transfer: load wins, INIT_SEED substituted
        seed_load = 1'b1; seed_in = 8'h00; out_ready = 1'b1;
        tick();
        seed_load = 1'b0; out_ready = 1'b0;
        chk("zseed_random", r0, 8'hAB);
        chk("zseed_fixed", f0, 1);
        tick();
        chk("zseed_fixed_end", f0, 0);
        seed_load = 1'b1; seed_in = 8'h5F;
        tick();
        seed_load = 1'b0;
        chk("seed_random", r0, 8'h5F);
        chk("seed_fixed", f0, 0);
        chk("seed_valid", v0, 1);
        out_ready = 1'b1;
        tick();
        chk("seed_adv", r0, model_adv(8'h5F, 1));

        // Two shifts per advance
        en0 = 1'b0; en1 = 1'b1;
        rst = 1'b1; out_ready = 1'b0; tick();
        rst = 1'b0; out_ready = 1'b1; #1;
        chk("s2_valid", v1, 1);
        chk("s2_r0", r1, 8'hAB);
        tick();
        chk("s2_r1", r1, 8'hAF);
        chk("s2_r1_model", r1, model_adv(8'hAB, 2));
        tick();
        chk("s2_r2", r1, 8'hBE);

        // Warmup of 4, out_ready irrelevant during warmup
        en1 = 1'b0; en2 = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_ready = $urandom_range(1); #1;
            chk("warm_valid", v2, 0);
            tick();
        end
        chk("warm_done_valid", v2, 1);
        chk("warm_done_random", r2, 8'hBE);

        rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("warm_rst_random", r2, 8'hAB);
        for (int i = 0; i < 4; i++) begin
            out_ready = $urandom_range(1); #1;
            chk("rewarm_valid", v2, 0);
            tick();
        end
        chk("rewarm_valid_up", v2, 1);
        chk("rewarm_random", r2, model_adv(8'hAB, 4));

        // Load during RUN with WARMUP>0: valid drops, warmup restarts from the new seed
        out_ready = 1'b0; seed_load = 1'b1; seed_in = 8'h5F;
        tick();
        seed_load = 1'b0;
        chk("wload_valid", v2, 0);
        chk("wload_random", r2, 8'h5F);
        tick(); tick(); tick(); tick();
        chk("wload_valid_up", v2, 1);
        chk("wload_random_up", r2, model_adv(8'h5F, 4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
